// File: rtl/cam_pkg.sv
// Shared constants, pixel type and FSM encoding for the camera frame-buffer writer.
package cam_pkg;

    localparam int unsigned IMG_W  = 320;
    localparam int unsigned IMG_H  = 240;
    localparam int unsigned ADDR_W = 17;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        StSync,
        StArmed,
        StCapture,
        StFrozen
    } cam_state_e;

endpackage

// File: rtl/cam_byte_assembler.sv
// Input register stage, vsync/href edge detection and pairing of camera bytes into pixels.
module cam_byte_assembler
    import cam_pkg::*;
(
    input  logic       pclk,
    input  logic       rstn,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] d,
    output logic       vsync_lvl,
    output logic       pix_valid,
    output rgb565_t    pix_data,
    output logic       line_end,
    output logic       frame_start,
    output logic       frame_end
);

    logic       vsync_q, vsync_qq;
    logic       href_q, href_qq;
    logic [7:0] d_q;
    logic [7:0] hi_q, hi_d;
    logic       phase_q, phase_d;

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
            href_q   <= 1'b0;
            href_qq  <= 1'b0;
            d_q      <= 8'h00;
            hi_q     <= 8'h00;
            phase_q  <= 1'b0;
        end else begin
            vsync_q  <= vsync;
            vsync_qq <= vsync_q;
            href_q   <= href;
            href_qq  <= href_q;
            d_q      <= d;
            hi_q     <= hi_d;
            phase_q  <= phase_d;
        end
    end

    always_comb begin
        vsync_lvl   = vsync_q;
        frame_start = vsync_qq & ~vsync_q;
        frame_end   = vsync_q & ~vsync_qq;
        line_end    = href_qq & ~href_q;
        // A byte coinciding with a vsync rise is dropped; phase restarts at every
        // frame boundary and whenever href is low, which discards a dangling odd byte.
        pix_valid   = href_q & phase_q & ~frame_end;
        pix_data    = rgb565_t'({hi_q, d_q});
        phase_d     = href_q & ~phase_q & ~frame_start & ~frame_end;
        hi_d        = (href_q && !phase_q) ? d_q : hi_q;
    end

endmodule

// File: rtl/cam_frame_writer.sv
// Camera-side frame-buffer writer: capture FSM, x/y/row-base counters, window clipping,
// frame counting and the sticky line/frame overrun flag.
module cam_frame_writer #(
    parameter int unsigned IMG_W  = cam_pkg::IMG_W,
    parameter int unsigned IMG_H  = cam_pkg::IMG_H,
    parameter int unsigned ADDR_W = cam_pkg::ADDR_W
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              freeze,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err
);

    import cam_pkg::rgb565_t;
    import cam_pkg::cam_state_e;
    import cam_pkg::StSync;
    import cam_pkg::StArmed;
    import cam_pkg::StCapture;
    import cam_pkg::StFrozen;

    // Counters saturate one past the window so overruns stay detectable.
    localparam int unsigned X_W = $clog2(IMG_W + 2);
    localparam int unsigned Y_W = $clog2(IMG_H + 2);
    localparam logic [X_W-1:0]    X_LIM    = X_W'(IMG_W);
    localparam logic [X_W-1:0]    X_MAX    = X_W'(IMG_W + 1);
    localparam logic [Y_W-1:0]    Y_LIM    = Y_W'(IMG_H);
    localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(IMG_H + 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    logic    vsync_lvl, pix_valid, line_end, frame_start, frame_end;
    rgb565_t pix_data;

    cam_byte_assembler u_asm (
        .pclk        (pclk),
        .rstn        (rstn),
        .vsync       (vsync),
        .href        (href),
        .d           (d),
        .vsync_lvl   (vsync_lvl),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .line_end    (line_end),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    cam_state_e        state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              done_q, done_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StSync;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        row_d   = row_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            StSync: begin
                if (vsync_lvl) state_d = StArmed;
            end
            StArmed: begin
                if (frame_start) begin
                    if (freeze) begin
                        state_d = StFrozen;
                    end else begin
                        state_d = StCapture;
                        x_d     = '0;
                        y_d     = '0;
                        row_d   = '0;
                    end
                end
            end
            StCapture: begin
                if (frame_end) begin
                    if (y_q != '0) begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + 8'd1;
                    end
                    if (y_q > Y_LIM) err_d = 1'b1;
                    state_d = StArmed;
                end else if (line_end) begin
                    if (x_q != '0) begin
                        if (y_q != Y_MAX) y_d = y_q + Y_W'(1);
                        if (y_q < Y_LIM) row_d = row_q + ROW_STEP;
                    end
                    if (x_q > X_LIM) err_d = 1'b1;
                    x_d = '0;
                end else if (pix_valid) begin
                    if (x_q < X_LIM && y_q < Y_LIM) begin
                        we_d   = 1'b1;
                        addr_d = row_q + ADDR_W'(x_q);
                        data_d = pix_data;
                    end
                    if (x_q != X_MAX) x_d = x_q + X_W'(1);
                end
            end
            StFrozen: begin
                if (frame_end) state_d = StArmed;
            end
            default: state_d = StSync;
        endcase
    end

    assign we         = we_q;
    assign wAddr      = addr_q;
    assign wData      = data_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;
    assign line_err   = err_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Randomized bench for cam_frame_writer with a frame-level reference model.
module tb_cam_frame_writer;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 12;
    localparam int ADDR_W = 9;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    logic              pclk = 1'b0;
    logic              rstn = 1'b0;
    logic              vsync = 1'b0;
    logic              href = 1'b0;
    logic [7:0]        d = 8'h00;
    logic              freeze = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [15:0]       wData;
    logic              frame_done;
    logic [7:0]        frame_cnt;
    logic              line_err;

    cam_frame_writer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .pclk       (pclk),
        .rstn       (rstn),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .freeze     (freeze),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .line_err   (line_err)
    );

    always #5 pclk = ~pclk;

    int         checks = 0;
    int         errors = 0;
    wr_t        got_q[$];
    wr_t        exp_q[$];
    wr_t        mon_w;
    int         m_y = 0;
    bit         m_cap = 1'b0;
    bit         m_armed = 1'b0;
    bit         exp_done_now = 1'b0;
    logic [7:0] exp_cnt = 8'h00;
    bit         exp_err = 1'b0;
    bit         inc_mode = 1'b0;
    logic [7:0] byte_ctr = 8'h00;

    always @(negedge pclk) begin
        if (rstn && we === 1'b1) begin
            mon_w.addr = int'(wAddr);
            mon_w.data = wData;
            got_q.push_back(mon_w);
        end
    end

    // Returns -1 when captured writes equal the expected list, else first differing index.
    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i].addr != exp_q[i].addr || got_q[i].data !== exp_q[i].data) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic send_line(input int nbytes);
        logic [7:0] b[$];
        wr_t        w;
        int         npix;
        for (int i = 0; i < nbytes; i++) begin
            @(posedge pclk); #1;
            href = 1'b1;
            if (inc_mode) begin
                d = byte_ctr;
                byte_ctr++;
            end else begin
                d = 8'($urandom);
            end
            b.push_back(d);
        end
        @(posedge pclk); #1;
        href = 1'b0;
        d    = 8'($urandom);
        npix = nbytes / 2;
        if (m_cap) begin
            for (int i = 0; i < npix; i++) begin
                if (i < IMG_W && m_y < IMG_H) begin
                    w.addr = m_y * IMG_W + i;
                    w.data = {b[2*i], b[2*i+1]};
                    exp_q.push_back(w);
                end
            end
            if (npix > 0) m_y++;
            if (npix > IMG_W) exp_err = 1'b1;
        end
        repeat (2) @(posedge pclk);
    endtask

    task automatic vsync_rise(output bit early, output bit at2, output logic [7:0] cnt2);
        @(posedge pclk); #1;
        vsync = 1'b1;
        exp_done_now = m_cap && (m_y >= 1);
        if (exp_done_now) exp_cnt++;
        if (m_cap && m_y > IMG_H) exp_err = 1'b1;
        m_cap   = 1'b0;
        m_armed = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        early = frame_done;
        @(negedge pclk);
        at2  = frame_done;
        cnt2 = frame_cnt;
        repeat (3) @(posedge pclk);
    endtask

    task automatic vsync_fall();
        @(posedge pclk); #1;
        vsync = 1'b0;
        if (m_armed) begin
            m_cap   = !freeze;
            m_armed = 1'b0;
            m_y     = 0;
        end
        got_q.delete();
        exp_q.delete();
        repeat (3) @(posedge pclk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if ({we, wAddr, wData, frame_done, frame_cnt, line_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b wAddr=%0d wData=%h done=%b cnt=%0d err=%b, required all 0",
                     we, wAddr, wData, frame_done, frame_cnt, line_err);
        end
        rstn = 1'b1;
        repeat (2) @(posedge pclk);
    endtask

    task automatic test_partial_after_reset();
        bit e, a; logic [7:0] c;
        for (int l = 0; l < 3; l++) send_line(2 * IMG_W);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL partial_no_writes: got %0d writes, required 0", got_q.size());
        end
        vsync_rise(e, a, c);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL partial_no_done: frame_done=%b, required 0", a);
        end
        vsync_fall();
        for (int l = 0; l < IMG_H; l++) send_line(2 * IMG_W);
        vsync_rise(e, a, c);
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL first_frame_writes: %0d writes, diff at %0d, required %0d matching",
                     got_q.size(), first_diff(), exp_q.size());
        end
        checks++;
        if (e !== 1'b0 || a !== 1'b1 || c !== 8'd1) begin
            errors++;
            $display("FAIL first_frame_done: early=%b done=%b cnt=%0d, required 0/1/1", e, a, c);
        end
    endtask

    task automatic test_full_frame_inc();
        bit e, a; logic [7:0] c;
        int n;
        logic [15:0] last_exp;
        vsync_fall();
        inc_mode = 1'b1;
        byte_ctr = 8'h00;
        for (int l = 0; l < IMG_H; l++) send_line(2 * IMG_W);
        inc_mode = 1'b0;
        vsync_rise(e, a, c);
        n = 2 * IMG_W * IMG_H;
        last_exp = {8'(n - 2), 8'(n - 1)};
        checks++;
        if (got_q.size() != IMG_W * IMG_H) begin
            errors++;
            $display("FAIL inc_write_count: got %0d, required %0d", got_q.size(), IMG_W * IMG_H);
        end
        checks++;
        if (got_q.size() == 0 || got_q[0].addr != 0 || got_q[0].data !== 16'h0001) begin
            errors++;
            $display("FAIL inc_first_write: size=%0d, required addr 0 data 0001", got_q.size());
        end
        checks++;
        if (got_q.size() == 0 || got_q[got_q.size()-1].addr != IMG_W * IMG_H - 1 ||
            got_q[got_q.size()-1].data !== last_exp) begin
            errors++;
            $display("FAIL inc_last_write: size=%0d, required addr %0d data %h",
                     got_q.size(), IMG_W * IMG_H - 1, last_exp);
        end
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL inc_frame_writes: diff at index %0d, required none", first_diff());
        end
        checks++;
        if (e !== 1'b0 || a !== 1'b1 || c !== exp_cnt) begin
            errors++;
            $display("FAIL inc_frame_done: early=%b done=%b cnt=%0d, required 0/1/%0d",
                     e, a, c, exp_cnt);
        end
    endtask

    task automatic test_odd_line();
        bit e, a; logic [7:0] c;
        vsync_fall();
        send_line(7);
        send_line(2 * IMG_W);
        vsync_rise(e, a, c);
        checks++;
        if (got_q.size() != 3 + IMG_W) begin
            errors++;
            $display("FAIL odd_write_count: got %0d, required %0d", got_q.size(), 3 + IMG_W);
        end
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL odd_writes: diff at index %0d, required none", first_diff());
        end
    endtask

    task automatic test_freeze();
        bit e, a; logic [7:0] c;
        vsync_fall();
        send_line(2 * IMG_W);
        send_line(2 * IMG_W);
        freeze = 1'b1;
        send_line(2 * IMG_W);
        send_line(2 * IMG_W);
        vsync_rise(e, a, c);
        checks++;
        if (first_diff() != -1 || a !== 1'b1 || c !== exp_cnt) begin
            errors++;
            $display("FAIL freeze_current_frame: writes=%0d done=%b cnt=%0d, required %0d/1/%0d",
                     got_q.size(), a, c, exp_q.size(), exp_cnt);
        end
        vsync_fall();
        for (int l = 0; l < 3; l++) send_line(2 * IMG_W);
        vsync_rise(e, a, c);
        checks++;
        if (got_q.size() != 0 || a !== 1'b0) begin
            errors++;
            $display("FAIL frozen_frame: writes=%0d done=%b, required 0/0", got_q.size(), a);
        end
        freeze = 1'b0;
        vsync_fall();
        send_line(2 * IMG_W);
        send_line(2 * IMG_W);
        vsync_rise(e, a, c);
        checks++;
        if (first_diff() != -1 || got_q.size() != 2 * IMG_W || a !== 1'b1 || c !== exp_cnt) begin
            errors++;
            $display("FAIL resume_after_freeze: writes=%0d done=%b cnt=%0d, required %0d/1/%0d",
                     got_q.size(), a, c, 2 * IMG_W, exp_cnt);
        end
    endtask

    task automatic test_long_line();
        bit e, a; logic [7:0] c;
        vsync_fall();
        checks++;
        if (line_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_before_overrun: line_err=%b, required 0", line_err);
        end
        send_line(2 * IMG_W);
        send_line(2 * IMG_W + 2);
        send_line(2 * IMG_W);
        vsync_rise(e, a, c);
        checks++;
        if (line_err !== 1'b1) begin
            errors++;
            $display("FAIL long_line_err: line_err=%b, required 1", line_err);
        end
        checks++;
        if (got_q.size() != 3 * IMG_W || got_q[2 * IMG_W].addr != 2 * IMG_W) begin
            errors++;
            $display("FAIL long_line_next_row: writes=%0d, required %0d with row 2 at %0d",
                     got_q.size(), 3 * IMG_W, 2 * IMG_W);
        end
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL long_line_writes: diff at index %0d, required none", first_diff());
        end
    endtask

    task automatic test_random_frames();
        bit e, a; logic [7:0] c;
        int nl;
        for (int f = 0; f < 5; f++) begin
            freeze = ($urandom_range(0, 3) == 0);
            vsync_fall();
            nl = $urandom_range(IMG_H - 1, IMG_H + 2);
            for (int l = 0; l < nl; l++) begin
                send_line($urandom_range(0, 2 * IMG_W + 5));
                freeze = 1'($urandom);
            end
            vsync_rise(e, a, c);
            checks++;
            if (first_diff() != -1) begin
                errors++;
                $display("FAIL random_writes[%0d]: %0d writes diff at %0d, required %0d matching",
                         f, got_q.size(), first_diff(), exp_q.size());
            end
            checks++;
            if (a !== exp_done_now || c !== exp_cnt || line_err !== exp_err) begin
                errors++;
                $display("FAIL random_status[%0d]: done=%b cnt=%0d err=%b, required %b/%0d/%b",
                         f, a, c, line_err, exp_done_now, exp_cnt, exp_err);
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit e, a; logic [7:0] c;
        vsync_fall();
        for (int l = 0; l < 3; l++) send_line(2 * IMG_W);
        for (int i = 0; i < 10; i++) begin
            @(posedge pclk); #1;
            href = 1'b1;
            d    = 8'($urandom);
        end
        // Byte 7 closed pixel 3 two cycles ago, so its write strobe is high now.
        #2;
        checks++;
        if (we !== 1'b1) begin
            errors++;
            $display("FAIL mid_write_active: we=%b, required 1", we);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || frame_cnt !== 8'd0 || line_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: we=%b cnt=%0d err=%b, required 0/0/0", we, frame_cnt, line_err);
        end
        m_armed = 1'b0;
        m_cap   = 1'b0;
        exp_cnt = 8'h00;
        exp_err = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        rstn = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(posedge pclk); #1;
            href = 1'b1;
            d    = 8'($urandom);
        end
        @(posedge pclk); #1;
        href = 1'b0;
        repeat (2) @(posedge pclk);
        send_line(2 * IMG_W);
        send_line(2 * IMG_W);
        vsync_rise(e, a, c);
        checks++;
        if (got_q.size() != 0 || a !== 1'b0 || c !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_discard: writes=%0d done=%b cnt=%0d, required 0/0/0",
                     got_q.size(), a, c);
        end
        vsync_fall();
        send_line(2 * IMG_W);
        send_line(2 * IMG_W);
        vsync_rise(e, a, c);
        checks++;
        if (first_diff() != -1 || got_q.size() != 2 * IMG_W || a !== 1'b1 || c !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_capture: writes=%0d done=%b cnt=%0d, required %0d/1/1",
                     got_q.size(), a, c, 2 * IMG_W);
        end
    endtask

    initial begin
        test_reset();
        test_partial_after_reset();
        test_full_frame_inc();
        test_odd_line();
        test_freeze();
        test_long_line();
        test_random_frames();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
